// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned MEM_ARB_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY0 = 2'b01,
        BUSY1 = 2'b10
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester/downstream bus of the memory port arbiter; slave = arbiter side.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned WIDTH = MEM_ARB_WIDTH
);
    logic             req0_valid;
    logic             req1_valid;
    logic [WIDTH-1:0] req0_addr;
    logic [WIDTH-1:0] req1_addr;
    logic             req0_grant;
    logic             req1_grant;
    logic             req0_done;
    logic             req1_done;
    logic             mem_valid;
    logic [WIDTH-1:0] mem_addr;
    logic             mem_done;
    logic             mux_sel;

    modport slave (
        input  req0_valid, req1_valid, req0_addr, req1_addr, mem_done,
        output req0_grant, req1_grant, req0_done, req1_done,
               mem_valid, mem_addr, mux_sel
    );

    modport master (
        output req0_valid, req1_valid, req0_addr, req1_addr, mem_done,
        input  req0_grant, req1_grant, req0_done, req1_done,
               mem_valid, mem_addr, mux_sel
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Two-way winner selection: round-robin by default, requester 1 always wins
// ties when MEM_ARB_FIXED_PRIO_EN is defined.
module rr_pick (
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_grant_i,
    output logic winner_o,
    output logic any_o
);

    assign any_o = valid0_i | valid1_i;

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
    assign winner_o          = valid1_i;
`else
    // On a tie, whoever was not served last wins.
    assign winner_o = (valid0_i & valid1_i) ? ~last_grant_i : valid1_i;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates two requesters onto one shared memory port with back-to-back
// hand-over; tie policy selected by MEM_ARB_FIXED_PRIO_EN (see rr_pick).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WIDTH = MEM_ARB_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    arb_state_t       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic             mux_sel_q, mux_sel_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       done_q, done_d;

    logic busy;
    logic cur_req;
    logic finishing;
    logic arb_last_grant;
    logic winner;
    logic any_req;

    assign busy      = (state_q != IDLE);
    assign cur_req   = (state_q == BUSY1);
    assign finishing = busy & bus.mem_done;

    // A finishing transaction updates last_grant before the hand-over is arbitrated.
    assign arb_last_grant = finishing ? cur_req : last_grant_q;

    rr_pick u_rr_pick (
        .valid0_i     (bus.req0_valid),
        .valid1_i     (bus.req1_valid),
        .last_grant_i (arb_last_grant),
        .winner_o     (winner),
        .any_o        (any_req)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_addr_d   = mem_addr_q;
        mux_sel_d    = mux_sel_q;
        grant_d      = '0;
        done_d       = '0;

        if (!busy || finishing) begin
            if (finishing) begin
                done_d[cur_req] = 1'b1;
                last_grant_d    = cur_req;
                state_d         = IDLE;
            end
            if (any_req) begin
                state_d         = winner ? BUSY1 : BUSY0;
                mem_addr_d      = winner ? bus.req1_addr : bus.req0_addr;
                mux_sel_d       = winner;
                grant_d[winner] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            mem_addr_q   <= '0;
            mux_sel_q    <= 1'b0;
            grant_q      <= '0;
            done_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_addr_q   <= mem_addr_d;
            mux_sel_q    <= mux_sel_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
        end
    end

    assign bus.mem_valid  = busy;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mux_sel    = mux_sel_q;
    assign bus.req0_grant = grant_q[0];
    assign bus.req1_grant = grant_q[1];
    assign bus.req0_done  = done_q[0];
    assign bus.req1_done  = done_q[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; expectations follow MEM_ARB_FIXED_PRIO_EN.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    mem_port_arbiter_if #(.WIDTH(64)) bus ();

    mem_port_arbiter #(.WIDTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output vector order: {grant0, grant1, done0, done1, mem_valid, mux_sel}
    task automatic chk_out(input string tag, input logic [5:0] exp);
        chk(tag, {58'd0, bus.req0_grant, bus.req1_grant, bus.req0_done,
                  bus.req1_done, bus.mem_valid, bus.mux_sel}, {58'd0, exp});
    endtask

    logic [5:0] e;

    initial begin
        reset          = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_addr  = '0;
        bus.req1_addr  = '0;
        bus.mem_done   = 1'b0;
        tick();
        tick();
        chk_out("reset_outs", 6'b000000);
        chk("reset_addr", bus.mem_addr, 64'h0);

        // mem_done in IDLE must be ignored
        reset        = 1'b0;
        bus.mem_done = 1'b1;
        tick();
        chk_out("idle_done_ignored", 6'b000000);
        bus.mem_done = 1'b0;

        // Single request
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 64'h1000;
        tick();
        chk_out("single_grant", 6'b100010);
        chk("single_addr", bus.mem_addr, 64'h1000);
        bus.req0_valid = 1'b0;
        tick();
        chk_out("single_busy1", 6'b000010);
        tick();
        chk_out("single_busy2", 6'b000010);
        chk("single_addr_hold", bus.mem_addr, 64'h1000);
        bus.mem_done = 1'b1;
        tick();
        chk_out("single_done", 6'b001000);
        bus.mem_done = 1'b0;
        tick();
        chk_out("single_idle", 6'b000000);

        // Tie after reset: requester 0 first, then 1 with no bubble
        reset = 1'b1;
        tick();
        reset          = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_addr  = 64'h10;
        bus.req1_addr  = 64'h20;
        tick();
`ifdef MEM_ARB_FIXED_PRIO_EN
        chk_out("tie_first", 6'b010011);
        chk("tie_first_addr", bus.mem_addr, 64'h20);
        bus.req1_valid = 1'b0;
        bus.mem_done   = 1'b1;
        tick();
        chk_out("tie_second", 6'b100110);
        chk("tie_second_addr", bus.mem_addr, 64'h10);
        bus.req0_valid = 1'b0;
        tick();
        chk_out("tie_end", 6'b001000);
        tick();
        chk_out("tie_idle", 6'b000000);
`else
        chk_out("tie_first", 6'b100010);
        chk("tie_first_addr", bus.mem_addr, 64'h10);
        bus.req0_valid = 1'b0;
        bus.mem_done   = 1'b1;
        tick();
        chk_out("tie_second", 6'b011011);
        chk("tie_second_addr", bus.mem_addr, 64'h20);
        bus.req1_valid = 1'b0;
        tick();
        chk_out("tie_end", 6'b000101);
        tick();
        chk_out("tie_idle", 6'b000001);
`endif
        bus.mem_done = 1'b0;

        // Sustained contention with 1-cycle downstream (last served: 1)
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.mem_done   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
`ifdef MEM_ARB_FIXED_PRIO_EN
            e = {1'b0, 1'b1, 1'b0, (i > 0), 1'b1, 1'b1};
`else
            e = {(i % 2 == 0), (i % 2 == 1), (i > 0) && (i % 2 == 1),
                 (i > 0) && (i % 2 == 0), 1'b1, (i % 2 == 1)};
            chk("no_overlap0", {63'd0, bus.req0_grant & bus.req0_done}, 64'd0);
            chk("no_overlap1", {63'd0, bus.req1_grant & bus.req1_done}, 64'd0);
`endif
            chk_out($sformatf("contend_%0d", i), e);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        chk_out("contend_end", 6'b000101);
        bus.mem_done = 1'b0;

        // Reset in BUSY1 with mem_done in the same cycle
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 64'hABC;
        tick();
        chk_out("b1_grant", 6'b010011);
        chk("b1_addr", bus.mem_addr, 64'hABC);
        bus.req1_valid = 1'b0;
        tick();
        chk_out("b1_busy", 6'b000011);
        reset          = 1'b1;
        bus.mem_done   = 1'b1;
        bus.req0_valid = 1'b1;
        tick();
        chk_out("b1_reset", 6'b000000);
        chk("b1_reset_addr", bus.mem_addr, 64'h0);
        reset          = 1'b0;
        bus.mem_done   = 1'b0;
        bus.req0_valid = 1'b0;
        tick();
        chk_out("b1_after_reset", 6'b000000);

        // Withdrawn requester 1 during BUSY0
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 64'h500;
        tick();
        chk_out("wd_grant0", 6'b100010);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        tick();
        chk_out("wd_busy", 6'b000010);
        bus.req1_valid = 1'b0;
        tick();
        chk_out("wd_busy2", 6'b000010);
        bus.mem_done = 1'b1;
        tick();
        chk_out("wd_done0", 6'b001000);
        bus.mem_done = 1'b0;
        tick();
        chk_out("wd_idle", 6'b000000);

        // Own valid still high at done edge is a fresh request
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 64'h600;
        tick();
        chk_out("regrant_first", 6'b100010);
        bus.mem_done = 1'b1;
        tick();
        chk_out("regrant_second", 6'b101010);
        chk("regrant_addr", bus.mem_addr, 64'h600);
        bus.req0_valid = 1'b0;
        tick();
        chk_out("regrant_done", 6'b001000);
        bus.mem_done = 1'b0;
        tick();
        chk_out("regrant_idle", 6'b000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
